// File: rtl/i2c_eeprom_arb_if.sv
// rtl/i2c_eeprom_arb_if.sv - client request/response and EEPROM engine command bus
interface i2c_eeprom_arb_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;

  logic              eng_wr;
  logic              eng_rd;
  logic [ADDR_W-1:0] eng_addr;
  logic [DATA_W-1:0] eng_wdata;
  logic [DATA_W-1:0] eng_rdata;
  logic              eng_ack;

  // Arbiter side: serves the clients, drives the engine
  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  eng_rdata, eng_ack,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output eng_wr, eng_rd, eng_addr, eng_wdata
  );

  // Environment side: clients plus the engine
  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output eng_rdata, eng_ack,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  eng_wr, eng_rd, eng_addr, eng_wdata
  );
endinterface

// File: rtl/i2c_eeprom_arb.sv
// rtl/i2c_eeprom_arb.sv - two-client round-robin sequencer in front of the i2c EEPROM engine
// Optional post-write tWR wait state enabled by defining I2C_ARB_TWR_EN.
module i2c_eeprom_arb #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 8,
  parameter int WR_DELAY_CYC = 5000
) (
  input  logic                clk,
  input  logic                rst_n,
  i2c_eeprom_arb_if.slave     bus,
  output logic                o_busy,
  output logic                o_owner
);

`ifdef I2C_ARB_TWR_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_BUSY    = 3'd2,
    S_RELEASE = 3'd3,
    S_TWR     = 3'd4
  } state_t;

  localparam int CNT_W = (WR_DELAY_CYC > 1) ? $clog2(WR_DELAY_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_DELAY_CYC - 1);

  logic [CNT_W-1:0]  r_cnt;
`else
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_BUSY    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  logic w_unused_twr_cfg;
  assign w_unused_twr_cfg = (WR_DELAY_CYC != 0);
`endif

  state_t            r_state;
  logic              r_owner;
  logic              r_we;
  logic              r_busy;
  logic              r_eng_wr;
  logic              r_eng_rd;
  logic [ADDR_W-1:0] r_eng_addr;
  logic [DATA_W-1:0] r_eng_wdata;
  logic              r_rsp0_valid;
  logic              r_rsp1_valid;
  logic [DATA_W-1:0] r_rsp0_rdata;
  logic [DATA_W-1:0] r_rsp1_rdata;

  logic              w_gnt0;
  logic              w_gnt1;

  // Grant decision in IDLE: a lone requester wins, a tie goes to the client that did not own last
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == S_IDLE) begin
      if (bus.req0_valid && (!bus.req1_valid || r_owner)) begin
        w_gnt0 = 1'b1;
      end else if (bus.req1_valid) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp0_rdata = r_rsp0_rdata;
  assign bus.rsp1_rdata = r_rsp1_rdata;
  assign bus.eng_wr     = r_eng_wr;
  assign bus.eng_rd     = r_eng_rd;
  assign bus.eng_addr   = r_eng_addr;
  assign bus.eng_wdata  = r_eng_wdata;
  assign o_busy         = r_busy;
  assign o_owner        = r_owner;

  // Sequencer FSM: capture request, pulse command, wait for ack, respond, settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b1;
      r_we         <= 1'b0;
      r_busy       <= 1'b0;
      r_eng_wr     <= 1'b0;
      r_eng_rd     <= 1'b0;
      r_eng_addr   <= '0;
      r_eng_wdata  <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp1_rdata <= '0;
`ifdef I2C_ARB_TWR_EN
      r_cnt        <= '0;
`endif
    end else begin
      // Command and response strobes are single-cycle unless re-asserted below
      r_eng_wr     <= 1'b0;
      r_eng_rd     <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_owner     <= w_gnt1;
            r_we        <= w_gnt1 ? bus.req1_we    : bus.req0_we;
            r_eng_addr  <= w_gnt1 ? bus.req1_addr  : bus.req0_addr;
            r_eng_wdata <= w_gnt1 ? bus.req1_wdata : bus.req0_wdata;
            r_eng_wr    <= w_gnt1 ? bus.req1_we    : bus.req0_we;
            r_eng_rd    <= w_gnt1 ? !bus.req1_we   : !bus.req0_we;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_state <= S_BUSY;
        end

        S_BUSY: begin
          if (bus.eng_ack) begin
            if (r_owner) begin
              r_rsp1_valid <= 1'b1;
              r_rsp1_rdata <= r_we ? '0 : bus.eng_rdata;
            end else begin
              r_rsp0_valid <= 1'b1;
              r_rsp0_rdata <= r_we ? '0 : bus.eng_rdata;
            end
            r_state <= S_RELEASE;
          end
        end

        S_RELEASE: begin
`ifdef I2C_ARB_TWR_EN
          if (r_we) begin
            r_cnt   <= '0;
            r_state <= S_TWR;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
`else
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
`endif
        end

`ifdef I2C_ARB_TWR_EN
        S_TWR: begin
          if (r_cnt == CNT_LAST) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_arb.sv
// tb/tb_i2c_eeprom_arb.sv - directed vector bench for i2c_eeprom_arb
module tb_i2c_eeprom_arb;

  logic clk;
  logic rst_n;
  logic busy;
  logic owner;
  int   total;
  int   bad;
  logic [7:0] last_rdata [2];

  i2c_eeprom_arb_if #(.ADDR_W(11), .DATA_W(8)) bus ();

  i2c_eeprom_arb #(.ADDR_W(11), .DATA_W(8), .WR_DELAY_CYC(20)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_busy  (busy),
    .o_owner (owner)
  );

  typedef struct {
    bit         cl;
    bit         we;
    logic [10:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         dly;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit cl, input bit v, input bit we, input logic [10:0] a, input logic [7:0] d);
    if (cl) begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
    end else begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
    end
  endtask

  function automatic logic rdy(input bit cl);
    return cl ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic rspv(input bit cl);
    return cl ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction

  function automatic logic [7:0] rspd(input bit cl);
    return cl ? bus.rsp1_rdata : bus.rsp0_rdata;
  endfunction

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  // One complete transaction from a single client with an engine-model ack
  task automatic do_xfer(input vec_t v);
    @(negedge clk);
    set_req(v.cl, 1'b1, v.we, v.addr, v.wdata);
    #1;
    chk("ready_own", {31'b0, rdy(v.cl)}, 32'd1);
    chk("ready_other", {31'b0, rdy(!v.cl)}, 32'd0);
    @(negedge clk);
    set_req(v.cl, 1'b0, v.we, v.addr, v.wdata);
    chk("eng_wr", {31'b0, bus.eng_wr}, {31'b0, v.we});
    chk("eng_rd", {31'b0, bus.eng_rd}, {31'b0, !v.we});
    chk("eng_addr", {21'b0, bus.eng_addr}, {21'b0, v.addr});
    chk("eng_wdata", {24'b0, bus.eng_wdata}, {24'b0, v.wdata});
    chk("owner", {31'b0, owner}, {31'b0, v.cl});
    chk("busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i <= v.dly; i++) begin
      @(negedge clk);
      chk("cmd_low", {30'b0, bus.eng_wr, bus.eng_rd}, 32'd0);
      chk("addr_held", {21'b0, bus.eng_addr}, {21'b0, v.addr});
      chk("no_early_rsp", {30'b0, bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
    end
    bus.eng_rdata = v.rdata;
    bus.eng_ack = 1'b1;
    @(negedge clk);
    bus.eng_ack = 1'b0;
    bus.eng_rdata = 8'hEE;
    chk("rsp_valid", {31'b0, rspv(v.cl)}, 32'd1);
    chk("rsp_rdata", {24'b0, rspd(v.cl)}, {24'b0, v.exp_rdata});
    chk("rsp_other", {31'b0, rspv(!v.cl)}, 32'd0);
    chk("rdata_other_hold", {24'b0, rspd(!v.cl)}, {24'b0, last_rdata[!v.cl]});
    last_rdata[v.cl] = v.exp_rdata;
    @(negedge clk);
    chk("rsp_pulse", {30'b0, bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
    wait_idle();
  endtask

  initial begin
    int cnt;
    int exp_gap;
    bit e;
    bit pe;
    total = 0;
    bad = 0;
    last_rdata[0] = 8'h00;
    last_rdata[1] = 8'h00;
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 11'h0, 8'h0);
    set_req(1'b1, 1'b0, 1'b0, 11'h0, 8'h0);
    bus.eng_ack = 1'b0;
    bus.eng_rdata = 8'h00;

    vecs[0] = '{cl: 1'b0, we: 1'b1, addr: 11'h123, wdata: 8'hA5, rdata: 8'hFF, dly: 3, exp_rdata: 8'h00};
    vecs[1] = '{cl: 1'b1, we: 1'b0, addr: 11'h7FF, wdata: 8'h00, rdata: 8'h3C, dly: 2, exp_rdata: 8'h3C};
    vecs[2] = '{cl: 1'b0, we: 1'b0, addr: 11'h000, wdata: 8'h11, rdata: 8'h5A, dly: 0, exp_rdata: 8'h5A};
    vecs[3] = '{cl: 1'b1, we: 1'b1, addr: 11'h400, wdata: 8'hFF, rdata: 8'h81, dly: 1, exp_rdata: 8'h00};
    vecs[4] = '{cl: 1'b1, we: 1'b0, addr: 11'h001, wdata: 8'h00, rdata: 8'hC3, dly: 4, exp_rdata: 8'hC3};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_eng_cmd", {30'b0, bus.eng_wr, bus.eng_rd}, 32'd0);
    chk("rst_eng_addr", {21'b0, bus.eng_addr}, 32'd0);
    chk("rst_eng_wdata", {24'b0, bus.eng_wdata}, 32'd0);
    chk("rst_rsp_valid", {30'b0, bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
    chk("rst_rsp_rdata", {16'b0, bus.rsp0_rdata, bus.rsp1_rdata}, 32'd0);
    chk("rst_ready", {30'b0, bus.req0_ready, bus.req1_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_owner", {31'b0, owner}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Spurious ack in IDLE
    @(negedge clk);
    bus.eng_rdata = 8'h99;
    bus.eng_ack = 1'b1;
    @(negedge clk);
    bus.eng_ack = 1'b0;
    chk("spur_rsp", {30'b0, bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
    chk("spur_busy", {31'b0, busy}, 32'd0);
    chk("spur_rdata", {16'b0, bus.rsp0_rdata, bus.rsp1_rdata}, 32'd0);
    @(negedge clk);
    chk("spur_cmd", {30'b0, bus.eng_wr, bus.eng_rd}, 32'd0);
    chk("spur_owner", {31'b0, owner}, 32'd1);

    // Table of single-client transactions
    for (int i = 0; i < 5; i++) begin
      do_xfer(vecs[i]);
    end

    // Reset pulsed while BUSY drops the operation
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b1, 11'h2AA, 8'h55);
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b1, 11'h2AA, 8'h55);
    chk("rb_issue", {31'b0, bus.eng_wr}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rb_busy", {31'b0, busy}, 32'd0);
    chk("rb_owner", {31'b0, owner}, 32'd1);
    chk("rb_addr", {21'b0, bus.eng_addr}, 32'd0);
    chk("rb_wdata", {24'b0, bus.eng_wdata}, 32'd0);
    chk("rb_rdata", {16'b0, bus.rsp0_rdata, bus.rsp1_rdata}, 32'd0);
    last_rdata[0] = 8'h00;
    last_rdata[1] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rb_no_rsp", {30'b0, bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
      chk("rb_no_cmd", {30'b0, bus.eng_wr, bus.eng_rd}, 32'd0);
    end
    do_xfer('{cl: 1'b1, we: 1'b0, addr: 11'h0F0, wdata: 8'h00, rdata: 8'h6D, dly: 1, exp_rdata: 8'h6D});

    // Both clients held valid: grants alternate 0,1,0,1 and ack-to-next-command gap is bounded
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b1, 11'h011, 8'h77);
    set_req(1'b1, 1'b1, 1'b0, 11'h022, 8'h00);
    for (int g = 0; g < 4; g++) begin
      e = g[0];
      pe = !e;
      cnt = 0;
      while (!(bus.eng_wr || bus.eng_rd) && cnt < 60) begin
        @(negedge clk);
        cnt++;
        if (cnt == 1 && g > 0) begin
          bus.eng_ack = 1'b0;
          chk("rr_rsp_valid", {31'b0, rspv(pe)}, 32'd1);
          chk("rr_rsp_other", {31'b0, rspv(e)}, 32'd0);
          chk("rr_rsp_rdata", {24'b0, rspd(pe)}, pe ? {24'b0, 8'h40 + 8'(g - 1)} : 32'd0);
        end
      end
      chk("rr_cmd_seen", {30'b0, bus.eng_wr, bus.eng_rd}, e ? 32'd1 : 32'd2);
      chk("rr_owner", {31'b0, owner}, {31'b0, e});
      chk("rr_addr", {21'b0, bus.eng_addr}, e ? 32'h022 : 32'h011);
      if (g > 0) begin
`ifdef I2C_ARB_TWR_EN
        exp_gap = pe ? 3 : 23;
`else
        exp_gap = 3;
`endif
        chk("rr_gap", cnt, exp_gap);
      end
      @(negedge clk);
      bus.eng_rdata = 8'h40 + 8'(g);
      bus.eng_ack = 1'b1;
    end
    @(negedge clk);
    bus.eng_ack = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 11'h0, 8'h0);
    set_req(1'b1, 1'b0, 1'b0, 11'h0, 8'h0);
    chk("rr_last_rsp", {31'b0, bus.rsp1_valid}, 32'd1);
    chk("rr_last_rdata", {24'b0, bus.rsp1_rdata}, 32'h43);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("final_quiet", {30'b0, bus.eng_wr, bus.eng_rd}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
